mouse_ctrl_regs: RTL
====================

Name: mouse_ctrl_regs

Overview:
- Parametrised successor of the PS/2 mouse register wrapper: a synchronous memory-mapped register block that consumes decoded mouse packets, accumulates scaled X/Y position with optional min/max clamping, and queues button-change events in a FIFO with interrupt.
- Sits between the PS/2 mouse decoder (packet side) and the CPU bus (register side).
- Single clock domain; no tristate on the bus.

Parameters:
- POS_W, 32, width of position and bound registers (signed two's complement), 16..32.
- FIFO_DEPTH, 8, button-event FIFO entries, power of two, 2..64.
- SCALE_W, 5, width of scale registers; shift amount.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Addr  in  4  register address.
- WrData  in  32  write data.
- RD  in  1  read strobe, one cycle per access.
- WR  in  1  write strobe, one cycle per access.
- RdData  out  32  read data, registered.
- pkt_valid  in  1  decoder has a packet.
- pkt_ready  out  1  block accepts the packet this cycle.
- pkt_btn  in  3  {middle,right,left}.
- pkt_dx  in  9  signed X increment.
- pkt_dy  in  9  signed Y increment.
- Irq  out  1  level interrupt.

Behaviour:
- Register map (Addr):
  - 0 POS_X (rw).
  - 1 POS_Y (rw).
  - 2 STATUS (ro): [2:0] current buttons, [3] fifo_empty, [4] fifo_full, [5] overflow sticky, [15:8] fifo count.
  - 3 SCALE_X (rw, SCALE_W bits).
  - 4 SCALE_Y (rw, SCALE_W bits).
  - 5 MIN_X, 6 MAX_X, 7 MIN_Y, 8 MAX_Y (rw).
  - 9 CTRL (rw): [0] enable, [1] clamp_en, [2] irq_en.
  - 10 EVENT (ro, pops): [31] valid, [5:3] old buttons, [2:0] new buttons.
  - 11 CLR (wo): writing bit0=1 clears overflow.
  - Unmapped: read 0, writes ignored.
- Register widths on the bus:
  - POS/MIN/MAX sign-extended to 32 on read; low POS_W bits taken on write.
- Reset values:
  - RdData=0, Irq=0, pkt_ready=0.
  - POS_X/POS_Y=0, SCALE=0.
  - MIN_X/MIN_Y = most negative POS_W value; MAX_X/MAX_Y = most positive POS_W value.
  - CTRL=0, FIFO empty, overflow=0, button shadow=0.
- Read timing:
  - RdData is valid the cycle after RD and holds until the next RD.
  - RD and WR together: WR takes effect, RdData returns the pre-write value.
- Packet handshake:
  - pkt_ready = CTRL.enable, registered and updated the cycle after a CTRL write.
  - A packet transfers when pkt_valid & pkt_ready, at most one per cycle.
  - When disabled, packets stall upstream and are not dropped.
- Accumulate (in the transfer cycle; state updated at the next edge):
  - inc = sign-extend(dx to POS_W) << SCALE_X. Shift amounts >= POS_W give inc=0. Bits shifted out are lost.
  - sum = POS_X + inc, computed at POS_W+1 bits.
  - clamp_en=0: POS_X = sum[POS_W-1:0] (wrap).
  - clamp_en=1: sum is saturated to [MIN_X, MAX_X] using the full POS_W+1 value.
  - If MIN_X > MAX_X, the result is MAX_X.
  - Y uses identical rules with dy and SCALE_Y.
- Host write vs. packet, same cycle:
  - A host write to POS_X wins for X; Y still accumulates, and vice versa.
  - A write to SCALE or bounds in the same cycle applies from the next packet.
- Button events:
  - On transfer, if pkt_btn != shadow, push {shadow, pkt_btn}. The shadow updates on every transfer.
  - FIFO full: entry dropped, overflow set (sticky).
- EVENT read:
  - Non-empty: returns the head with valid=1 and pops.
  - Empty: returns 0, no pop.
  - Push and pop in the same cycle when full: the pop frees a slot first, the push succeeds, count is unchanged, no overflow.
- Irq (registered, 1 cycle latency): irq_en & (!fifo_empty | overflow).
- Reset asserted mid-packet or mid-read: all state cleared immediately; no partial updates survive.

Test Plan:
- Reset, read all registers:
  - POS=0, MIN_X reads 0x80000000, MAX_X 0x7FFFFFFF (POS_W=32), CTRL=0, STATUS=0x0008, pkt_ready=0.
- CTRL=1, SCALE_X=2, packet dx=+5, dy=-3 (0x1FD):
  - POS_X=20, POS_Y=0xFFFFFFFD.
  - RdData valid exactly 1 cycle after RD.
- clamp_en=1, MIN_X=0, MAX_X=100, POS_X=90, dx=+20:
  - POS_X=100.
  - Then dx=-256 gives POS_X=0.
  - With clamp_en=0 and POS_X=0x7FFFFFFF, dx=+1 wraps to 0x80000000.
- Same-cycle host write POS_X=7 and packet dx=3, dy=4 from POS=(0,0):
  - POS_X=7, POS_Y=4.
- FIFO_DEPTH=8, nine packets alternating btn 001/000:
  - count=8, fifo_full=1, overflow=1, Irq=1.
  - First EVENT read = 0x80000001.
  - Writing CLR=1 clears overflow.
  - Eight EVENT reads drain the FIFO.
  - The ninth read returns 0; Irq drops after the FIFO empties and overflow is cleared.
- CTRL.enable=0 with pkt_valid held high for 10 cycles:
  - No position change; no packet consumed.
  - Re-enable: exactly one transfer per cycle while valid.

Source files
------------

// File: rtl/mouse_ctrl_regs_if.sv
// Bus and packet-side signal bundle for the mouse control register block.
// The master drives host strobes and decoded packets; the slave is the register block.
interface mouse_ctrl_regs_if;
    logic [3:0]  Addr;
    logic [31:0] WrData;
    logic        RD;
    logic        WR;
    logic [31:0] RdData;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [2:0]  pkt_btn;
    logic [8:0]  pkt_dx;
    logic [8:0]  pkt_dy;
    logic        Irq;

    modport master (
        output Addr, WrData, RD, WR, pkt_valid, pkt_btn, pkt_dx, pkt_dy,
        input  RdData, pkt_ready, Irq
    );

    modport slave (
        input  Addr, WrData, RD, WR, pkt_valid, pkt_btn, pkt_dx, pkt_dy,
        output RdData, pkt_ready, Irq
    );
endinterface

// File: rtl/mouse_ctrl_regs.sv
// Memory-mapped mouse register block: scaled X/Y accumulation with optional
// clamping, plus a button-change event FIFO with a level interrupt.
module mouse_ctrl_regs #(
    parameter int POS_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SCALE_W    = 5
) (
    input logic              Clk,
    input logic              Reset,
    mouse_ctrl_regs_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] A_POS_X   = 4'd0;
    localparam logic [3:0] A_POS_Y   = 4'd1;
    localparam logic [3:0] A_STATUS  = 4'd2;
    localparam logic [3:0] A_SCALE_X = 4'd3;
    localparam logic [3:0] A_SCALE_Y = 4'd4;
    localparam logic [3:0] A_MIN_X   = 4'd5;
    localparam logic [3:0] A_MAX_X   = 4'd6;
    localparam logic [3:0] A_MIN_Y   = 4'd7;
    localparam logic [3:0] A_MAX_Y   = 4'd8;
    localparam logic [3:0] A_CTRL    = 4'd9;
    localparam logic [3:0] A_EVENT   = 4'd10;
    localparam logic [3:0] A_CLR     = 4'd11;

    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};

    logic signed [POS_W-1:0] pos_x, pos_y, min_x, max_x, min_y, max_y;
    logic signed [POS_W-1:0] next_x, next_y;
    logic [SCALE_W-1:0]      scale_x, scale_y;
    logic [2:0]              ctrl;
    logic [2:0]              shadow;
    logic                    overflow;
    logic [5:0]              fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [31:0]             rd_val;
    logic                    xfer, pop, push_req, push, fifo_full, fifo_empty;

    // Scaled increment, then sum one bit wider so saturation sees the true result.
    function automatic logic signed [POS_W-1:0] accum(
        input logic signed [POS_W-1:0] pos,
        input logic [8:0]              d,
        input logic [SCALE_W-1:0]      sh,
        input logic                    clamp,
        input logic signed [POS_W-1:0] lo,
        input logic signed [POS_W-1:0] hi
    );
        logic signed [POS_W-1:0] inc;
        logic signed [POS_W:0]   sum;
        inc = POS_W'($signed(d));
        if (32'(sh) >= POS_W) inc = '0;
        else                  inc = inc << sh;
        sum = (POS_W+1)'(pos) + (POS_W+1)'(inc);
        if (!clamp)                     return sum[POS_W-1:0];
        if (lo > hi)                    return hi;
        if (sum > (POS_W+1)'(hi))       return hi;
        if (sum < (POS_W+1)'(lo))       return lo;
        return sum[POS_W-1:0];
    endfunction

    assign xfer       = bus.pkt_valid & bus.pkt_ready;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pop        = bus.RD && (bus.Addr == A_EVENT) && !fifo_empty;
    assign push_req   = xfer && (bus.pkt_btn != shadow);
    // A same-cycle pop frees the slot the push needs.
    assign push       = push_req && (!fifo_full || pop);

    assign next_x = accum(pos_x, bus.pkt_dx, scale_x, ctrl[1], min_x, max_x);
    assign next_y = accum(pos_y, bus.pkt_dy, scale_y, ctrl[1], min_y, max_y);

    always_comb begin
        rd_val = '0;
        case (bus.Addr)
            A_POS_X:   rd_val = 32'(pos_x);
            A_POS_Y:   rd_val = 32'(pos_y);
            A_STATUS:  rd_val = {16'd0, 8'(count), 2'b00, overflow, fifo_full, fifo_empty, shadow};
            A_SCALE_X: rd_val = 32'(scale_x);
            A_SCALE_Y: rd_val = 32'(scale_y);
            A_MIN_X:   rd_val = 32'(min_x);
            A_MAX_X:   rd_val = 32'(max_x);
            A_MIN_Y:   rd_val = 32'(min_y);
            A_MAX_Y:   rd_val = 32'(max_y);
            A_CTRL:    rd_val = {29'd0, ctrl};
            A_EVENT:   rd_val = fifo_empty ? 32'd0 : {1'b1, 25'd0, fifo_mem[rd_ptr]};
            default:   rd_val = '0;
        endcase
    end

    // NOTE: storage holds no reset; the pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= {shadow, bus.pkt_btn};
    end

    // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x         <= '0;
            pos_y         <= '0;
            min_x         <= POS_MIN;
            max_x         <= POS_MAX;
            min_y         <= POS_MIN;
            max_y         <= POS_MAX;
            scale_x       <= '0;
            scale_y       <= '0;
            ctrl          <= '0;
            shadow        <= '0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.RdData    <= '0;
            bus.pkt_ready <= 1'b0;
            bus.Irq       <= 1'b0;
        end else begin
            if (bus.RD) bus.RdData <= rd_val;

            if (xfer) begin
                pos_x  <= next_x;
                pos_y  <= next_y;
                shadow <= bus.pkt_btn;
            end

            if (bus.WR) begin
                case (bus.Addr)
                    A_POS_X:   pos_x   <= bus.WrData[POS_W-1:0];
                    A_POS_Y:   pos_y   <= bus.WrData[POS_W-1:0];
                    A_SCALE_X: scale_x <= bus.WrData[SCALE_W-1:0];
                    A_SCALE_Y: scale_y <= bus.WrData[SCALE_W-1:0];
                    A_MIN_X:   min_x   <= bus.WrData[POS_W-1:0];
                    A_MAX_X:   max_x   <= bus.WrData[POS_W-1:0];
                    A_MIN_Y:   min_y   <= bus.WrData[POS_W-1:0];
                    A_MAX_Y:   max_y   <= bus.WrData[POS_W-1:0];
                    A_CTRL: begin
                        ctrl          <= bus.WrData[2:0];
                        bus.pkt_ready <= bus.WrData[0];
                    end
                    default: ;
                endcase
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (push_req && !push)                            overflow <= 1'b1;
            else if (bus.WR && bus.Addr == A_CLR && bus.WrData[0]) overflow <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            bus.Irq <= ctrl[2] & (!fifo_empty | overflow);
        end
    end
endmodule
